// File: rtl/rv32_mem_master_pkg.sv
// Shared definitions for the RV32 load/store bus master.
//
// Holds the bus width, the request size encoding, the master FSM state
// encoding and the memory-map constants used by the master and by anything
// that talks to it. A small helper decides whether a size/address pair can
// be issued on the bus in a single aligned access.
package rv32_mem_master_pkg;

    // Data bus width and the number of byte lanes it carries.
    localparam int BUS_W     = 32;
    localparam int BUS_BYTES = BUS_W / 8;

    // Memory map.
    localparam logic [31:0] RAM_BASE = 32'h2040_0000;

    // Encoding of req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } mem_size_e;

    // Master FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // True when the access fits naturally inside one bus word.
    function automatic logic size_ok(input mem_size_e size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = (addr_lo[0] == 1'b0);
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32_mem_master_lane_align.sv
// rv32_lane_align: combinational byte-lane steering for the RV32 bus master.
//
// Store side: turns a right-aligned store value plus size and address low
// bits into byte-lane write enables and lane-replicated write data.
// Load side: picks the addressed byte/half out of a raw bus word and sign-
// or zero-extends it to 32 bits.
//
// Ports
//   st_size, st_addr_lo, st_data  store request fields
//   st_wen, st_wdata              lane enables / replicated data
//   ld_size, ld_addr_lo           size and address low bits of the load
//   ld_unsigned                   1 = zero-extend, 0 = sign-extend
//   ld_raw                        word returned by the responder
//   ld_data                       extracted, extended load result
module rv32_lane_align
    import rv32_mem_master_pkg::*;
(
    input  logic [1:0]       st_size,
    input  logic [1:0]       st_addr_lo,
    input  logic [BUS_W-1:0] st_data,
    output logic [3:0]       st_wen,
    output logic [BUS_W-1:0] st_wdata,
    input  logic [1:0]       ld_size,
    input  logic [1:0]       ld_addr_lo,
    input  logic             ld_unsigned,
    input  logic [BUS_W-1:0] ld_raw,
    output logic [BUS_W-1:0] ld_data
);

    logic [BUS_W-1:0] byte_rep;
    logic [BUS_W-1:0] half_rep;
    logic [7:0]       raw_byte [BUS_BYTES];
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic             fill;

    // The responder picks whichever lanes the enables select, so the
    // value is copied into every lane rather than shifted into one.
    genvar gi;
    generate
        for (gi = 0; gi < BUS_BYTES; gi++) begin : g_lane
            assign byte_rep[gi*8 +: 8] = st_data[7:0];
            assign half_rep[gi*8 +: 8] = st_data[(gi % 2)*8 +: 8];
            assign raw_byte[gi]        = ld_raw[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        st_wen   = 4'b0000;
        st_wdata = '0;
        case (mem_size_e'(st_size))
            SIZE_BYTE: begin
                st_wen   = 4'b0001 << st_addr_lo;
                st_wdata = byte_rep;
            end
            SIZE_HALF: begin
                st_wen   = 4'b0011 << st_addr_lo;
                st_wdata = half_rep;
            end
            SIZE_WORD: begin
                st_wen   = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_wen   = 4'b0000;
                st_wdata = '0;
            end
        endcase
    end

    always_comb begin
        sel_byte = raw_byte[ld_addr_lo];
        sel_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        fill     = 1'b0;
        ld_data  = '0;
        case (mem_size_e'(ld_size))
            SIZE_BYTE: begin
                fill    = ~ld_unsigned & sel_byte[7];
                ld_data = {{24{fill}}, sel_byte};
            end
            SIZE_HALF: begin
                fill    = ~ld_unsigned & sel_half[15];
                ld_data = {{16{fill}}, sel_half};
            end
            SIZE_WORD: begin
                ld_data = ld_raw;
            end
            default: begin
                ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/rv32_mem_master.sv
// rv32_mem_master: single-outstanding load/store master between an RV32 core
// and a valid/ready memory bus.
//
// A request is accepted in IDLE. Aligned requests drive the bus (BUS state)
// until the responder raises mem_ready or the timeout expires; misaligned
// or illegal requests answer with an error straight away. Every request
// ends in exactly one RESP cycle carrying resp_valid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       core request handshake
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request fields (store data right-aligned)
//   resp_valid, resp_rdata,
//   resp_err                    one-cycle response
//   mem_valid / mem_ready       bus handshake
//   mem_wen, mem_addr,
//   mem_wdata, mem_rdata        bus lane enables, address and data
module rv32_mem_master
    import rv32_mem_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [BUS_W-1:0] req_wdata,
    output logic             resp_valid,
    output logic [BUS_W-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [3:0]       mem_wen,
    output logic [31:0]      mem_addr,
    output logic [BUS_W-1:0] mem_wdata,
    input  logic [BUS_W-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             mem_valid_reg, mem_valid_next;
    logic [3:0]       mem_wen_reg, mem_wen_next;
    logic [31:0]      mem_addr_reg, mem_addr_next;
    logic [BUS_W-1:0] mem_wdata_reg, mem_wdata_next;

    logic             resp_valid_reg, resp_valid_next;
    logic             resp_err_reg, resp_err_next;
    logic [BUS_W-1:0] resp_rdata_reg, resp_rdata_next;

    // Request attributes needed again when the load data comes back.
    logic             we_reg, we_next;
    logic [1:0]       size_reg, size_next;
    logic             unsigned_reg, unsigned_next;

    logic [3:0]       st_wen;
    logic [BUS_W-1:0] st_wdata;
    logic [BUS_W-1:0] ld_data;
    logic             req_ok;

    rv32_lane_align u_lane_align (
        .st_size     (req_size),
        .st_addr_lo  (req_addr[1:0]),
        .st_data     (req_wdata),
        .st_wen      (st_wen),
        .st_wdata    (st_wdata),
        .ld_size     (size_reg),
        .ld_addr_lo  (mem_addr_reg[1:0]),
        .ld_unsigned (unsigned_reg),
        .ld_raw      (mem_rdata),
        .ld_data     (ld_data)
    );

    assign req_ok = size_ok(mem_size_e'(req_size), req_addr[1:0]);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        mem_valid_next  = mem_valid_reg;
        mem_wen_next    = mem_wen_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = resp_err_reg;
        resp_rdata_next = resp_rdata_reg;
        we_next         = we_reg;
        size_next       = size_reg;
        unsigned_next   = unsigned_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        mem_valid_next = 1'b1;
                        mem_wen_next   = req_we ? st_wen : 4'b0000;
                        mem_addr_next  = req_addr;
                        mem_wdata_next = req_we ? st_wdata : '0;
                        we_next        = req_we;
                        size_next      = req_size;
                        unsigned_next  = req_unsigned;
                        cnt_next       = '0;
                        state_next     = ST_BUS;
                    end else begin
                        // Never touches the bus: answer with an error directly.
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = '0;
                        state_next      = ST_RESP;
                    end
                end
            end

            ST_BUS: begin
                // A ready in the last counted cycle still completes the access.
                if (mem_ready) begin
                    mem_valid_next  = 1'b0;
                    mem_wen_next    = 4'b0000;
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b0;
                    resp_rdata_next = we_reg ? '0 : ld_data;
                    state_next      = ST_RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    mem_valid_next  = 1'b0;
                    mem_wen_next    = 4'b0000;
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                    resp_rdata_next = '0;
                    state_next      = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_RESP: begin
                // mem_ready is deliberately not looked at here: a registered
                // responder may still show the ready of the finished access.
                state_next = ST_IDLE;
            end

            default: begin
                state_next     = ST_IDLE;
                mem_valid_next = 1'b0;
                mem_wen_next   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            mem_valid_reg  <= 1'b0;
            mem_wen_reg    <= 4'b0000;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mem_valid_reg  <= mem_valid_next;
            mem_wen_reg    <= mem_wen_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            we_reg         <= we_next;
            size_reg       <= size_next;
            unsigned_reg   <= unsigned_next;
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign mem_valid  = mem_valid_reg;
    assign mem_wen    = mem_wen_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_rv32_mem_master.sv
// Self-checking bench for rv32_mem_master: directed cases followed by
// randomized accesses, with expectations computed from byte/lane arithmetic.
module tb_rv32_mem_master;
    import rv32_mem_master_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder model: ready during the ready_delay-th cycle of mem_valid
    // (0 = never). With stale_en the ready lingers one cycle after valid drops.
    int ready_delay = 0;
    bit stale_en = 1'b0;
    int bus_cnt = 0;
    bit ready_from_bus = 1'b0;

    always #5 clk = ~clk;

    rv32_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always @(negedge clk) begin
        if (!rst_n) begin
            bus_cnt        = 0;
            mem_ready      = 1'b0;
            ready_from_bus = 1'b0;
        end else if (mem_valid) begin
            bus_cnt++;
            mem_ready      = (ready_delay != 0) && (bus_cnt == ready_delay);
            ready_from_bus = mem_ready;
        end else begin
            mem_ready      = stale_en && ready_from_bus;
            ready_from_bus = 1'b0;
            bus_cnt        = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access, starting and ending 1 time unit after a rising edge with
    // the DUT in IDLE. keep leaves req_valid high after acceptance.
    task automatic access(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rw, input int d, input bit keep);
        bit          legal;
        bit          eerr;
        int          elat;
        int          nb;
        int          cyc;
        logic [3:0]  ewen;
        logic [31:0] ewdata, erdata, tmp, mask;

        legal = (size == 2'd0) || (size == 2'd1 && addr[0] == 1'b0) ||
                (size == 2'd2 && addr[1:0] == 2'b00);
        ewen   = 4'b0000;
        ewdata = 32'h0;
        if (we) begin
            if (size == 2'd0) begin
                ewen   = 4'(1 << addr[1:0]);
                ewdata = {24'h0, wd[7:0]} * 32'h0101_0101;
            end else if (size == 2'd1) begin
                ewen   = 4'(3 << addr[1:0]);
                ewdata = {16'h0, wd[15:0]} * 32'h0001_0001;
            end else begin
                ewen   = 4'hF;
                ewdata = wd;
            end
        end
        nb     = 8 << size;
        mask   = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        tmp    = (rw >> (8 * addr[1:0])) & mask;
        if (!uns && nb < 32 && tmp[nb-1]) tmp = tmp | ~mask;
        erdata = we ? 32'h0 : tmp;
        eerr   = 1'b0;
        elat   = d;
        if (d == 0 || d > TO) begin
            eerr   = 1'b1;
            erdata = 32'h0;
            elat   = TO;
        end

        mem_rdata    = rw;
        ready_delay  = d;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;

        if (!legal) begin
            $display("txn we=%0d size=%0d addr=%h -> rejected (misaligned/illegal)", we, size, addr);
            chk("bad_resp_valid", 32'(resp_valid), 32'd1);
            chk("bad_resp_err",   32'(resp_err),   32'd1);
            chk("bad_resp_rdata", resp_rdata,      32'h0);
            chk("bad_mem_valid",  32'(mem_valid),  32'd0);
            @(posedge clk); #1;
            chk("bad_resp_drop",  32'(resp_valid), 32'd0);
            chk("bad_mem_valid2", 32'(mem_valid),  32'd0);
            chk("bad_ready_back", 32'(req_ready),  32'd1);
            return;
        end

        chk("mem_valid_rise", 32'(mem_valid), 32'd1);
        chk("mem_wen",        32'(mem_wen),   32'(ewen));
        chk("mem_addr",       mem_addr,       addr);
        chk("mem_wdata",      mem_wdata,      ewdata);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        chk("resp_quiet",     32'(resp_valid), 32'd0);

        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (resp_valid !== 1'b1) begin
                chk("hold_valid", 32'(mem_valid), 32'd1);
                chk("hold_wen",   32'(mem_wen),   32'(ewen));
                chk("hold_addr",  mem_addr,       addr);
                chk("hold_wdata", mem_wdata,      ewdata);
            end
        end
        $display("txn we=%0d size=%0d uns=%0d addr=%h wd=%h rw=%h d=%0d -> lat=%0d err=%0d rdata=%h",
                 we, size, uns, addr, wd, rw, d, cyc, resp_err, resp_rdata);
        chk("latency",        32'(cyc),        32'(elat));
        chk("resp_err",       32'(resp_err),   32'(eerr));
        chk("resp_rdata",     resp_rdata,      erdata);
        chk("resp_mem_valid", 32'(mem_valid),  32'd0);
        chk("resp_mem_wen",   32'(mem_wen),    32'd0);
        @(posedge clk); #1;
        chk("resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("ready_again",    32'(req_ready),  32'd1);
        chk("idle_mem_valid", 32'(mem_valid),  32'd0);
        chk("rdata_hold",     resp_rdata,      erdata);
        chk("err_hold",       32'(resp_err),   32'(eerr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_rdata    = 32'h0;
        mem_ready    = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_valid",  32'(mem_valid),  32'd0);
        chk("rst_mem_wen",    32'(mem_wen),    32'd0);
        chk("rst_mem_addr",   mem_addr,        32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata,      32'h0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Store byte into lane 1.
        access(1'b1, 2'd0, 1'b0, RAM_BASE + 32'h5, 32'h0000_00AB, 32'h0, 3, 1'b0);
        // Signed then unsigned half load from the upper half.
        access(1'b0, 2'd1, 1'b0, RAM_BASE + 32'h2, 32'h0, 32'h8001_1234, 2, 1'b0);
        access(1'b0, 2'd1, 1'b1, RAM_BASE + 32'h2, 32'h0, 32'h8001_1234, 2, 1'b0);
        // Misaligned word, misaligned half, illegal size.
        access(1'b0, 2'd2, 1'b0, RAM_BASE + 32'h1, 32'h0, 32'h1234_5678, 2, 1'b0);
        access(1'b1, 2'd1, 1'b0, RAM_BASE + 32'h3, 32'hCAFE, 32'h0, 2, 1'b0);
        access(1'b0, 2'd3, 1'b0, RAM_BASE, 32'h0, 32'h0, 2, 1'b0);
        // Responder never ready: timeout.
        access(1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0, 32'h5555_5555, 0, 1'b0);
        // Ready in the last counted cycle wins over the timeout.
        access(1'b0, 2'd0, 1'b0, RAM_BASE + 32'h3, 32'h0, 32'h9A00_0000, TO, 1'b0);
        // Back-to-back with req_valid held and a stale ready in RESP.
        stale_en = 1'b1;
        access(1'b0, 2'd2, 1'b0, RAM_BASE + 32'h8, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);
        access(1'b1, 2'd1, 1'b0, RAM_BASE + 32'hA, 32'h0000_7E57, 32'h0, 2, 1'b0);
        stale_en = 1'b0;

        // Reset in the middle of a bus access.
        ready_delay  = 0;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_addr     = RAM_BASE + 32'h40;
        req_wdata    = 32'h1357_9BDF;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_mem_valid", 32'(mem_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        $display("txn reset during BUS");
        chk("abort_mem_valid0", 32'(mem_valid),  32'd0);
        chk("abort_mem_wen0",   32'(mem_wen),    32'd0);
        chk("abort_mem_addr0",  mem_addr,        32'h0);
        chk("abort_mem_wdata0", mem_wdata,       32'h0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_err",   32'(resp_err),   32'd0);
        chk("abort_resp_rdata", resp_rdata,      32'h0);
        chk("abort_req_ready",  32'(req_ready),  32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_resp", 32'(resp_valid), 32'd0);
            chk("post_rst_idle", 32'(req_ready),  32'd1);
        end
        access(1'b0, 2'd0, 1'b0, RAM_BASE + 32'h2, 32'h0, 32'h00F0_0000, 2, 1'b0);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rs;
            logic [31:0] ra;
            int          rd;
            rs = 2'($urandom_range(0, 3));
            ra = RAM_BASE + ($urandom & 32'h0000_0FFF);
            if ($urandom_range(0, 3) != 0 && rs != 2'd3)
                ra = ra & ~((32'd1 << rs) - 32'd1);
            rd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
            stale_en = bit'($urandom_range(0, 1));
            access(bit'($urandom_range(0, 1)), rs, bit'($urandom_range(0, 1)), ra,
                   $urandom, $urandom, rd, ($urandom_range(0, 3) == 0));
        end
        req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
